// File: rtl/jogador_pkg.sv
// Shared types and constants for the memory-game auto-player: state codes,
// reference play sequence, and the chaves/index/timer widths.
package jogador_pkg;
  localparam int CH_W  = 4;
  localparam int IDX_W = 4;
  localparam int TMR_W = 8;

  typedef enum logic [3:0] {
    OCIOSO     = 4'd0,
    PULSO_INI  = 4'd1,
    ESPERA_INI = 4'd2,
    APLICA     = 4'd3,
    SOLTA      = 4'd4,
    AGUARDA    = 4'd5,
    FIM_OK     = 4'd6,
    FIM_ERRO   = 4'd7
  } estado_e;

  // Element 0 is the rightmost entry: play 0 = 0001, play 15 = 0100.
  localparam logic [15:0][CH_W-1:0] SEQ = {
    4'b0100, 4'b0001, 4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b0010, 4'b0010,
    4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001
  };

  function automatic logic [CH_W-1:0] rotl1(input logic [CH_W-1:0] v);
    return {v[CH_W-2:0], v[CH_W-1]};
  endfunction
endpackage

// File: rtl/jogador_automatico_if.sv
// Player <-> game core handshake: player drives iniciar/chaves, core answers
// with pronto/acertou/errou.
interface jogador_automatico_if;
  import jogador_pkg::*;
  logic            iniciar;
  logic [CH_W-1:0] chaves;
  logic            pronto;
  logic            acertou;
  logic            errou;

  modport master (output iniciar, chaves, input pronto, acertou, errou);
  modport slave  (input iniciar, chaves, output pronto, acertou, errou);
endinterface

// File: rtl/temporizador_jogador.sv
// Loadable down-counter shared by all timed states; stops at zero.
module temporizador_jogador
  import jogador_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             carrega,
  input  logic             conta,
  input  logic [TMR_W-1:0] valor,
  output logic             zero
);
  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (carrega)                   cnt_d = valor;
    else if (conta && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/jogador_automatico.sv
// Hardware auto-player replaying the reference sequence into the game core.
// Optional JOGADOR_INJETA_ERRO_EN corrupts play ERRO_POS (rotated left by 1).
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int N_JOGADAS = 16,
  parameter int T_INICIAR = 5,
  parameter int T_JOGADA  = 10,
  parameter int T_ESPERA  = 10,
  parameter int T_TIMEOUT = 255
`ifdef JOGADOR_INJETA_ERRO_EN
  , parameter int ERRO_POS = 4
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 comecar,
  jogador_automatico_if.master jogo,
  output logic [IDX_W-1:0]     jogada_idx,
  output logic                 sucesso,
  output logic                 falha,
  output logic                 timeout,
  output logic [3:0]           db_estado
);
  // Timer is loaded with duration-1 on entry so each state lasts exactly T cycles.
  localparam logic [TMR_W-1:0] V_INI = TMR_W'(T_INICIAR - 1);
  localparam logic [TMR_W-1:0] V_JOG = TMR_W'(T_JOGADA - 1);
  localparam logic [TMR_W-1:0] V_ESP = TMR_W'(T_ESPERA - 1);
  localparam logic [TMR_W-1:0] V_TMO = TMR_W'(T_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(N_JOGADAS - 1);

  estado_e          state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             iniciar_q, iniciar_d, sucesso_q, sucesso_d;
  logic             falha_q, falha_d, timeout_q, timeout_d;
  logic [CH_W-1:0]  chaves_q, chaves_d;
  logic             carrega, zero, fim_in, ultima;
  logic [TMR_W-1:0] valor;

  temporizador_jogador u_tmr (
    .clock(clock), .reset(reset), .carrega(carrega), .conta(1'b1),
    .valor(valor), .zero(zero)
  );

  function automatic logic [CH_W-1:0] chaves_de(input logic [IDX_W-1:0] i);
`ifdef JOGADOR_INJETA_ERRO_EN
    return (i == IDX_W'(ERRO_POS)) ? rotl1(SEQ[i]) : SEQ[i];
`else
    return SEQ[i];
`endif
  endfunction

  assign fim_in = jogo.pronto & jogo.acertou;
  assign ultima = (idx_q == ULTIMO);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timeout_d = timeout_q;
    carrega   = 1'b0;
    valor     = '0;
    unique case (state_q)
      OCIOSO, FIM_OK, FIM_ERRO:
        if (comecar) begin
          state_d = PULSO_INI; idx_d = '0; timeout_d = 1'b0;
          carrega = 1'b1; valor = V_INI;
        end
      PULSO_INI:
        if (zero) begin state_d = ESPERA_INI; carrega = 1'b1; valor = V_ESP; end
      ESPERA_INI:
        if (zero) begin state_d = APLICA; carrega = 1'b1; valor = V_JOG; end
      APLICA, SOLTA:
        if (jogo.errou) state_d = FIM_ERRO;
        // Finish reported during the last play counts; any earlier one is a failure.
        else if (fim_in) state_d = ultima ? FIM_OK : FIM_ERRO;
        else if (zero) begin
          carrega = 1'b1;
          if (state_q == APLICA) begin
            state_d = SOLTA; valor = V_ESP;
          end else if (ultima) begin
            state_d = AGUARDA; valor = V_TMO;
          end else begin
            state_d = APLICA; valor = V_JOG; idx_d = idx_q + 1'b1;
          end
        end
      AGUARDA:
        if (jogo.errou)  state_d = FIM_ERRO;
        else if (fim_in) state_d = FIM_OK;
        else if (zero) begin state_d = FIM_ERRO; timeout_d = 1'b1; end
      default: state_d = OCIOSO;
    endcase
    iniciar_d = (state_d == PULSO_INI);
    chaves_d  = (state_d == APLICA) ? chaves_de(idx_d) : '0;
    sucesso_d = (state_d == FIM_OK);
    falha_d   = (state_d == FIM_ERRO);
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q   <= OCIOSO;
      idx_q     <= '0;
      iniciar_q <= 1'b0;
      chaves_q  <= '0;
      sucesso_q <= 1'b0;
      falha_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      iniciar_q <= iniciar_d;
      chaves_q  <= chaves_d;
      sucesso_q <= sucesso_d;
      falha_q   <= falha_d;
      timeout_q <= timeout_d;
    end

  assign jogo.iniciar = iniciar_q;
  assign jogo.chaves  = chaves_q;
  assign jogada_idx   = idx_q;
  assign sucesso      = sucesso_q;
  assign falha        = falha_q;
  assign timeout      = timeout_q;
  assign db_estado    = state_q;
endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: randomized rounds against a timeline model
// derived from the play schedule (cycle offset -> expected outputs).
module tb_jogador_automatico;
  localparam int N = 16, T_INI = 5, T_JOG = 10, T_ESP = 10, T_TMO = 255, ERRO_POS = 4;
  localparam int PLAY = T_JOG + T_ESP, T0 = T_INI + T_ESP, LEN = T0 + N * PLAY;
  localparam int K_OK = 0, K_ERR = 1, K_NONE = 2, K_EARLY = 3, K_BOTH = 4;

  int seq_ref [16] = '{1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 8, 1, 4};

  logic       clock = 1'b0, reset = 1'b0, comecar = 1'b0;
  logic [3:0] jogada_idx, db_estado;
  logic       sucesso, falha, timeout;
  int         n_chk = 0, n_err = 0;

  typedef struct { int st; int ini; int ch; int idx; int suc; int fal; int tmo; } exp_t;

  jogador_automatico_if jif ();

  jogador_automatico dut (
    .clock(clock), .reset(reset), .comecar(comecar), .jogo(jif.master),
    .jogada_idx(jogada_idx), .sucesso(sucesso), .falha(falha),
    .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Expected outputs t cycles after the round started, with no core reaction.
  function automatic exp_t nominal(input int t);
    exp_t e = '{default: 0};
    if (t < T_INI) begin
      e.st = 1; e.ini = 1;
    end else if (t < T0) begin
      e.st = 2;
    end else if (t < LEN) begin
      int p = (t - T0) / PLAY;
      e.idx = p;
      if ((t - T0) % PLAY < T_JOG) begin
        e.st = 3; e.ch = seq_ref[p];
`ifdef JOGADOR_INJETA_ERRO_EN
        if (p == ERRO_POS) e.ch = ((e.ch << 1) | (e.ch >> 3)) & 15;
`endif
      end else e.st = 4;
    end else if (t < LEN + T_TMO) begin
      e.st = 5; e.idx = N - 1;
    end else begin
      e.st = 7; e.idx = N - 1; e.fal = 1; e.tmo = 1;
    end
    return e;
  endfunction

  // A core reaction at cycle te lands the player in a final state at te+1.
  function automatic exp_t model(input int t, input int kind, input int te);
    exp_t e, b;
    if (kind == K_NONE || t <= te) return nominal(t);
    b = nominal(te);
    e = '{default: 0};
    e.idx = b.idx;
    if (kind == K_OK) begin e.st = 6; e.suc = 1; end
    else begin e.st = 7; e.fal = 1; end
    return e;
  endfunction

  task automatic check_all(input exp_t e);
    check("db_estado",  db_estado,   e.st);
    check("iniciar",    jif.iniciar, e.ini);
    check("chaves",     jif.chaves,  e.ch);
    check("jogada_idx", jogada_idx,  e.idx);
    check("sucesso",    sucesso,     e.suc);
    check("falha",      falha,       e.fal);
    check("timeout",    timeout,     e.tmo);
  endtask

  // Called at a negedge with the player idle or finished; rst_at >= 0 aborts there.
  task automatic run_round(input int kind_in, input int te_in, input int rst_at);
    exp_t e;
    int   kind = kind_in, te = te_in, t_end, r;
`ifdef JOGADOR_INJETA_ERRO_EN
    kind = K_ERR; te = T0 + ERRO_POS * PLAY;
`endif
    t_end = (kind == K_NONE) ? LEN + T_TMO + 6 : te + 7;
    comecar = 1'b1;
    for (int t = 0; t <= t_end; t++) begin
      @(negedge clock);
      e = model(t, kind, te);
      check_all(e);
      if (t == rst_at) begin
        reset = 1'b0; comecar = 1'b0;
        jif.pronto = 1'b0; jif.acertou = 1'b0; jif.errou = 1'b0;
        #1;
        check_all('{default: 0});
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_reset_state", db_estado, 0);
        return;
      end
      comecar = (e.st >= 1 && e.st <= 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      r = int'($urandom_range(0, 3));
      jif.pronto  = (r == 1);
      jif.acertou = (r == 2);
      jif.errou   = (kind == K_ERR || kind == K_BOTH) && t == te;
      if ((kind == K_OK || kind == K_EARLY || kind == K_BOTH) && t == te) begin
        jif.pronto = 1'b1; jif.acertou = 1'b1;
      end
    end
  endtask

  initial begin
    int kind, te;
    jif.pronto = 1'b0; jif.acertou = 1'b0; jif.errou = 1'b0;
    repeat (3) @(negedge clock);
    check_all('{default: 0});
    comecar = 1'b1;
    @(negedge clock);
    check("reset_holds_idle", db_estado, 0);
    comecar = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("idle_after_release", db_estado, 0);

    run_round(K_OK,    LEN + 3,            -1);
    run_round(K_OK,    LEN,                -1);
    run_round(K_ERR,   T0 + 4 * PLAY + 3,  -1);
    run_round(K_NONE,  0,                  -1);
    run_round(K_BOTH,  LEN + 10,           -1);
    run_round(K_EARLY, T0 + 2,             -1);
    run_round(K_OK,    LEN + 5,            T0 + 2 * PLAY + 4);
    run_round(K_ERR,   LEN - 1,            -1);

    for (int i = 0; i < 8; i++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        K_OK, K_BOTH: te = LEN + int'($urandom_range(0, T_TMO - 2));
        K_ERR:        te = T0 + int'($urandom_range(0, N * PLAY + T_TMO - 2));
        K_EARLY:      te = T0 + int'($urandom_range(0, (N - 1) * PLAY - 1));
        default:      te = 0;
      endcase
      run_round(kind, te, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
